scratch_ram_reader: RTL and testbench
=====================================

SCRATCH_RAM_READER -- requirements
Module: scratch_ram_reader

Interface
REQ-001 Parameter ADDR_W, default 8, Scratch RAM address width.
REQ-002 Parameter DATA_W, default 10, Scratch RAM data width.
REQ-003 The clock port SHALL be clk, 1 bit, input. All state advances on its rising edge.
REQ-004 The reset port SHALL be rst_n, 1 bit, input. Reset is asynchronous and active-low.
REQ-005 START  input  1  single-cycle request to begin a read sweep.
REQ-006 START_ADDR  input  ADDR_W  first address read; sampled on accepted START.
REQ-007 END_ADDR  input  ADDR_W  last address read; sampled on accepted START.
REQ-008 DATA_OUT  input  DATA_W  Scratch RAM read data; combinational from SCR_ADDR.
REQ-009 SCR_ADDR  output  ADDR_W  Scratch RAM address, registered.
REQ-010 SCR_WE  output  1  Scratch RAM write enable; SHALL be constant 0.
REQ-011 BUSY  output  1  high while the sweep is in progress.
REQ-012 DONE  output  1  one-cycle pulse at sweep completion.
REQ-013 ERR_CNT  output  ADDR_W+1  count of mismatching words in the last sweep.
REQ-014 FIRST_ERR_VALID  output  1  at least one mismatch seen in the last sweep.
REQ-015 FIRST_ERR_ADDR  output  ADDR_W  address of the first mismatch.

Function
REQ-016 The expected word SHALL be the address zero-extended to DATA_W bits (addr 0x2A -> 10'h02A).
REQ-017 The FSM SHALL have the states IDLE, READ and FIN.
REQ-018 IDLE with START=1: latch END_ADDR, load SCR_ADDR<=START_ADDR, clear ERR_CNT, FIRST_ERR_VALID and FIRST_ERR_ADDR, go to READ.
REQ-019 In each READ cycle, compare DATA_OUT with the expected word for the current SCR_ADDR on the same rising edge.
REQ-020 On a mismatch, ERR_CNT increments by 1. If FIRST_ERR_VALID=0, it is set and FIRST_ERR_ADDR<=SCR_ADDR.
REQ-021 READ with SCR_ADDR==latched END_ADDR: go to FIN. Otherwise SCR_ADDR<=SCR_ADDR+1, modulo 2^ADDR_W.
REQ-022 The sweep SHALL cost one cycle per address, so sweep length = ((END-START) mod 256)+1 cycles.
REQ-023 Wrap-around: END_ADDR<START_ADDR reads START..255, then 0..END. START_ADDR==END_ADDR reads exactly one word.
REQ-024 A full sweep (START=0, END=255) reads 256 words; ERR_CNT SHALL reach 256 without overflow.
REQ-025 FIN: DONE=1 for exactly one cycle, then go to IDLE. BUSY=1 only in READ.
REQ-026 START is ignored in READ and FIN. START in the IDLE cycle after FIN is accepted.
REQ-027 Result outputs SHALL hold until the next accepted START. SCR_ADDR holds its last value in IDLE.

Reset
REQ-028 rst_n=0 SHALL force: state IDLE, SCR_ADDR=0, BUSY=0, DONE=0, ERR_CNT=0, FIRST_ERR_VALID=0, FIRST_ERR_ADDR=0.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep immediately with no DONE pulse. The first START after release begins a fresh sweep.

Configuration
REQ-030 With macro SCR_RD_CHKSUM_EN defined, add output CHKSUM, 16 bits. It is cleared on accepted START and reset, and adds each zero-extended DATA_OUT read in READ, modulo 2^16.
REQ-031 Without SCR_RD_CHKSUM_EN, the CHKSUM port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 The ADDR_W and DATA_W defaults and the FSM state enum SHALL live in a shared package, scratch_ram_pkg, alongside the Scratch RAM.
REQ-033 The block SHALL be a single module with no sub-modules. The bench instantiates it with the existing Scratch_RAM.

Verification
REQ-034 RAM preloaded mem[a]=a for all a; START with 0/255 -> 256 BUSY cycles, DONE once, ERR_CNT=0, FIRST_ERR_VALID=0.
REQ-035 Same preload but mem[0x40]=0x3FF and mem[0x80]=0 -> ERR_CNT=2, FIRST_ERR_ADDR=0x40.
REQ-036 START with 0xFE/0x01 -> SCR_ADDR sequence FE,FF,00,01, then DONE. START with 0x10/0x10 -> one read, DONE on cycle 2.
REQ-037 START pulsed during READ -> ignored and sweep unchanged. rst_n=0 mid-sweep -> outputs at reset values and no DONE.
REQ-038 With SCR_RD_CHKSUM_EN and the identity preload, a 0..255 sweep -> CHKSUM=0x7F80.

Source files
------------

// File: rtl/scratch_ram_pkg.sv
// rtl/scratch_ram_pkg.sv - shared Scratch RAM widths and reader FSM state encoding
package scratch_ram_pkg;

    localparam int SCR_ADDR_W = 8;
    localparam int SCR_DATA_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/scratch_ram.sv
// rtl/scratch_ram.sv - Scratch RAM, synchronous write port, combinational read port
module scratch_ram
    import scratch_ram_pkg::*;
#(
    parameter int ADDR_W = SCR_ADDR_W,
    parameter int DATA_W = SCR_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: one word per clock when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/scratch_ram_reader.sv
// rtl/scratch_ram_reader.sv - sweeps Scratch RAM, checks mem[a]==a, counts mismatches (option: SCR_RD_CHKSUM_EN)
module scratch_ram_reader
    import scratch_ram_pkg::*;
#(
    parameter int ADDR_W = SCR_ADDR_W,
    parameter int DATA_W = SCR_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] scr_addr,
    output logic              scr_we,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_cnt,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr
`ifdef SCR_RD_CHKSUM_EN
    ,
    output logic [15:0]       chksum
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] end_q;
    logic [DATA_W-1:0] exp_word;
    logic              accept;
    logic              at_end;
    logic              mismatch;

    // The reader never writes the RAM
    assign scr_we   = 1'b0;

    assign accept   = (state == ST_IDLE) && start;
    assign at_end   = (scr_addr == end_q);
    assign exp_word = DATA_W'(scr_addr);
    assign mismatch = (data_out != exp_word);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: START only matters in IDLE; FIN always lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)  state_nxt = ST_READ;
            ST_READ: if (at_end) state_nxt = ST_FIN;
            ST_FIN:              state_nxt = ST_IDLE;
            default:             state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == ST_READ);
        done = (state == ST_FIN);
    end

    // Address walk and mismatch bookkeeping; results hold until next accepted START
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_addr        <= '0;
            end_q           <= '0;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (accept) begin
            scr_addr        <= start_addr;
            end_q           <= end_addr;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else if (state == ST_READ) begin
            if (mismatch) begin
                err_cnt <= err_cnt + {{ADDR_W{1'b0}}, 1'b1};
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= scr_addr;
                end
            end
            if (!at_end) begin
                scr_addr <= scr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef SCR_RD_CHKSUM_EN
    // Running 16-bit sum of every word read during the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chksum <= '0;
        end else if (accept) begin
            chksum <= '0;
        end else if (state == ST_READ) begin
            chksum <= chksum + 16'(data_out);
        end
    end
`endif

endmodule

// File: tb/tb_scratch_ram_reader.sv
// tb/tb_scratch_ram_reader.sv - directed bench for scratch_ram_reader with Scratch RAM (option: SCR_RD_CHKSUM_EN)
module tb_scratch_ram_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] start_addr = 8'h00;
    logic [7:0] end_addr = 8'h00;
    logic [9:0] data_out;
    logic [7:0] scr_addr;
    logic       scr_we;
    logic       busy;
    logic       done;
    logic [8:0] err_cnt;
    logic       first_err_valid;
    logic [7:0] first_err_addr;
`ifdef SCR_RD_CHKSUM_EN
    logic [15:0] chksum;
`endif

    logic       pl_we = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [9:0] pl_data = 10'h000;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] addr_q[$];

    always #5 clk = ~clk;

    scratch_ram u_ram (
        .clk   (clk),
        .we    (pl_we),
        .waddr (pl_addr),
        .wdata (pl_data),
        .raddr (scr_addr),
        .rdata (data_out)
    );

    scratch_ram_reader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_addr      (start_addr),
        .end_addr        (end_addr),
        .data_out        (data_out),
        .scr_addr        (scr_addr),
        .scr_we          (scr_we),
        .busy            (busy),
        .done            (done),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr)
`ifdef SCR_RD_CHKSUM_EN
        ,
        .chksum          (chksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: mem[a]=a; mode 1: identity with mem[40]=3FF, mem[80]=0; mode 2: all 3FF
    task automatic preload(input int mode);
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            pl_we   = 1'b1;
            pl_addr = 8'(a);
            if (mode == 2)                   pl_data = 10'h3FF;
            else if (mode == 1 && a == 'h40) pl_data = 10'h3FF;
            else if (mode == 1 && a == 'h80) pl_data = 10'h000;
            else                             pl_data = 10'(a);
        end
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Start a sweep and watch until DONE; ends on the negedge where DONE is seen
    task automatic run_sweep(input logic [7:0] s, input logic [7:0] e, input int inject_at,
                             output int busy_cyc, output int done_cyc);
        addr_q.delete();
        busy_cyc = 0;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        start_addr = s;
        end_addr = e;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc == inject_at) begin
                start = 1'b1;
                start_addr = 8'h55;
                end_addr = 8'h56;
            end else begin
                start = 1'b0;
            end
            if (busy) begin
                busy_cyc++;
                addr_q.push_back(scr_addr);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int bc;
        int dc;
        int done_seen;
        logic [31:0] packed_q;

        repeat (2) @(negedge clk);
        check("rst_scr_addr", 32'(scr_addr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
        check("rst_fev", 32'(first_err_valid), 32'h0);
        check("rst_fea", 32'(first_err_addr), 32'h0);
        check("scr_we", 32'(scr_we), 32'h0);
        rst_n = 1'b1;

        // Identity preload, full sweep
        preload(0);
        run_sweep(8'h00, 8'hFF, 0, bc, dc);
        check("full_busy_cycles", 32'(bc), 32'd256);
        check("full_done_cycle", 32'(dc), 32'd257);
        check("full_err_cnt", 32'(err_cnt), 32'h0);
        check("full_fev", 32'(first_err_valid), 32'h0);
`ifdef SCR_RD_CHKSUM_EN
        check("full_chksum", 32'(chksum), 32'h7F80);
`endif
        @(negedge clk);
        check("full_done_once", 32'(done), 32'h0);
        check("full_idle_busy", 32'(busy), 32'h0);
        check("full_addr_hold", 32'(scr_addr), 32'hFF);

        // Two corrupted words
        preload(1);
        run_sweep(8'h00, 8'hFF, 0, bc, dc);
        check("err2_err_cnt", 32'(err_cnt), 32'd2);
        check("err2_fev", 32'(first_err_valid), 32'h1);
        check("err2_fea", 32'(first_err_addr), 32'h40);

        // Wrap-around sweep
        preload(0);
        run_sweep(8'hFE, 8'h01, 0, bc, dc);
        check("wrap_busy_cycles", 32'(bc), 32'd4);
        packed_q = 32'h0;
        for (int i = 0; i < addr_q.size() && i < 4; i++) packed_q = (packed_q << 8) | 32'(addr_q[i]);
        check("wrap_addr_seq", packed_q, 32'hFEFF0001);
        check("wrap_done_cycle", 32'(dc), 32'd5);
        check("wrap_err_cnt", 32'(err_cnt), 32'h0);
        check("err_clear_fev", 32'(first_err_valid), 32'h0);

        // Single-word sweep, then START held through FIN and the following IDLE
        run_sweep(8'h10, 8'h10, 0, bc, dc);
        check("one_busy_cycles", 32'(bc), 32'd1);
        check("one_done_cycle", 32'(dc), 32'd2);
        start = 1'b1;
        start_addr = 8'h20;
        end_addr = 8'h21;
        @(negedge clk);
        check("fin_start_ignored_busy", 32'(busy), 32'h0);
        check("fin_start_ignored_addr", 32'(scr_addr), 32'h10);
        check("fin_done_once", 32'(done), 32'h0);
        @(negedge clk);
        start = 1'b0;
        check("idle_start_busy", 32'(busy), 32'h1);
        check("idle_start_addr", 32'(scr_addr), 32'h20);
        repeat (2) @(negedge clk);
        check("b2b_done", 32'(done), 32'h1);
        @(negedge clk);

        // START pulsed mid-sweep must not disturb it
        run_sweep(8'h00, 8'hFF, 100, bc, dc);
        check("inject_busy_cycles", 32'(bc), 32'd256);
        check("inject_done_cycle", 32'(dc), 32'd257);
        check("inject_end_addr", 32'(scr_addr), 32'hFF);

        // Every word wrong: counter reaches 256
        preload(2);
        run_sweep(8'h00, 8'hFF, 0, bc, dc);
        check("all_err_cnt", 32'(err_cnt), 32'h100);
        check("all_fea", 32'(first_err_addr), 32'h00);
        check("all_fev", 32'(first_err_valid), 32'h1);

        // Reset mid-sweep
        preload(1);
        @(negedge clk);
        start = 1'b1;
        start_addr = 8'h00;
        end_addr = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_err_cnt", 32'(err_cnt), 32'd1);
        check("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_scr_addr", 32'(scr_addr), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_err_cnt", 32'(err_cnt), 32'h0);
        check("arst_fev", 32'(first_err_valid), 32'h0);
        check("arst_fea", 32'(first_err_addr), 32'h0);
`ifdef SCR_RD_CHKSUM_EN
        check("arst_chksum", 32'(chksum), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("arst_no_done", 32'(done_seen), 32'h0);
        run_sweep(8'h3E, 8'h42, 0, bc, dc);
        check("fresh_busy_cycles", 32'(bc), 32'd5);
        check("fresh_err_cnt", 32'(err_cnt), 32'd1);
        check("fresh_fea", 32'(first_err_addr), 32'h40);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
